// File: rtl/cnn_row_window.sv
// cnn_row_window: K-row sliding window over a row stream with
// vertical stride, per-image last/frame-end marking and backpressure.
module cnn_row_window #(
  parameter int VALUE_BITS  = 8,
  parameter int WIDTH       = 28,
  parameter int IN_CHANNELS = 1,
  parameter int KERNAL_SIZE = 3,
  parameter int STRIDE      = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [VALUE_BITS-1:0] in_row_i [WIDTH][IN_CHANNELS],
  input  logic                  in_row_valid_i,
  output logic                  in_row_accept_o,
  input  logic                  in_row_last_i,
  output logic [VALUE_BITS-1:0] out_window_o
                                  [KERNAL_SIZE][WIDTH][IN_CHANNELS],
  output logic                  out_window_valid_o,
  input  logic                  out_window_ready_i,
  output logic                  out_window_last_o,
  output logic                  out_frame_end_o
);

  localparam int ROW_MAX = KERNAL_SIZE - 1 + STRIDE;
  localparam int RW = $clog2(ROW_MAX + 1);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNAL_SIZE - 1);
  localparam logic [RW-1:0] ROW_SAT   = RW'(ROW_MAX);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

  logic [VALUE_BITS-1:0] buf_q [KERNAL_SIZE][WIDTH][IN_CHANNELS];
  logic [VALUE_BITS-1:0] buf_d [KERNAL_SIZE][WIDTH][IN_CHANNELS];

  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          pend_q, pend_d;

  logic take;
  logic drain;
  logic full;
  logic produce;

  // Handshake decode: row taken, window consumed, window produced.
  // The first window of an image comes from row K-1; later ones
  // every STRIDE rows, counted by phase.
  always_comb begin
    take    = in_row_valid_i & in_row_accept_o;
    drain   = valid_q & out_window_ready_i;
    full    = (row_q >= ROW_FIRST);
    produce = take & full &
              ((row_q == ROW_FIRST) | (phase_q == PH_LAST));
  end

  // Row shift register: new row enters at the top, oldest at 0.
  always_comb begin
    buf_d = buf_q;
    if (take) begin
      for (int k = 0; k < KERNAL_SIZE - 1; k++) begin
        buf_d[k] = buf_q[k+1];
      end
      buf_d[KERNAL_SIZE-1] = in_row_i;
    end
  end

  // Counters, window flags and deferred frame-end for rows that
  // end an image without producing a window.
  always_comb begin
    row_d   = row_q;
    phase_d = phase_q;
    valid_d = valid_q;
    last_d  = last_q;
    pend_d  = 1'b0;
    if (drain) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (take) begin
      if (in_row_last_i) begin
        row_d   = '0;
        phase_d = '0;
        pend_d  = ~produce;
      end else begin
        if (row_q != ROW_SAT) begin
          row_d = row_q + 1'b1;
        end
        if (produce) begin
          phase_d = '0;
        end else if (full) begin
          phase_d = phase_q + 1'b1;
        end
      end
      if (produce) begin
        valid_d = 1'b1;
        last_d  = in_row_last_i;
      end
    end
  end

  // Row storage register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      buf_q <= '{default: '0};
    end else begin
      buf_q <= buf_d;
    end
  end

  // Control state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      row_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      row_q   <= row_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  // The window is the buffer itself: it only changes on a taken
  // row, and rows are refused while a window waits on ready.
  assign out_window_o       = buf_q;
  assign out_window_valid_o = valid_q;
  assign out_window_last_o  = last_q;
  assign in_row_accept_o    = reset_i &
                              (~valid_q | out_window_ready_i);
  assign out_frame_end_o    = pend_q | (drain & last_q);

endmodule

// File: tb/tb_cnn_row_window.sv
// tb_cnn_row_window: directed, table and random checks of
// cnn_row_window against a queue-based reference model.
module tb_cnn_row_window;

  localparam int W  = 28;
  localparam int CA = 2;
  localparam int CB = 1;
  localparam int K  = 3;
  localparam int SA = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] a_row [W][CA];
  logic [7:0] a_win [K][W][CA];
  logic a_in_valid, a_accept, a_in_last;
  logic a_valid, a_ready, a_last, a_fe;
  logic [7:0] a_tag;

  logic [7:0] b_row [W][CB];
  logic [7:0] b_win [K][W][CB];
  logic b_in_valid, b_accept, b_in_last;
  logic b_valid, b_ready, b_last, b_fe;

  cnn_row_window #(
    .VALUE_BITS(8), .WIDTH(W), .IN_CHANNELS(CA),
    .KERNAL_SIZE(K), .STRIDE(SA)
  ) dut_a (
    .clock_i(clk), .reset_i(rst_n),
    .in_row_i(a_row), .in_row_valid_i(a_in_valid),
    .in_row_accept_o(a_accept), .in_row_last_i(a_in_last),
    .out_window_o(a_win), .out_window_valid_o(a_valid),
    .out_window_ready_i(a_ready), .out_window_last_o(a_last),
    .out_frame_end_o(a_fe)
  );

  cnn_row_window #(
    .VALUE_BITS(8), .WIDTH(W), .IN_CHANNELS(CB),
    .KERNAL_SIZE(K), .STRIDE(2)
  ) dut_b (
    .clock_i(clk), .reset_i(rst_n),
    .in_row_i(b_row), .in_row_valid_i(b_in_valid),
    .in_row_accept_o(b_accept), .in_row_last_i(b_in_last),
    .out_window_o(b_win), .out_window_valid_o(b_valid),
    .out_window_ready_i(b_ready), .out_window_last_o(b_last),
    .out_frame_end_o(b_fe)
  );

  int n_pass = 0;
  int n_total = 0;
  bit rand_ready = 0;

  task automatic check(input bit ok, input string nm,
                       input int act, input int want);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d want %0d @%0t",
                  nm, act, want, $time);
  endtask

  function automatic logic [7:0] pix(input logic [7:0] t,
                                     input int w, input int c);
    return t + 8'(w * 7) + 8'(c * 13);
  endfunction

  function automatic bit win_ok_a(input logic [7:0] t0,
                                  input logic [7:0] t1,
                                  input logic [7:0] t2);
    logic [7:0] t [K];
    bit ok = 1;
    t[0] = t0; t[1] = t1; t[2] = t2;
    for (int k = 0; k < K; k++)
      for (int w = 0; w < W; w++)
        for (int c = 0; c < CA; c++)
          if (a_win[k][w][c] !== pix(t[k], w, c)) ok = 0;
    return ok;
  endfunction

  function automatic bit win_ok_b(input logic [7:0] t0,
                                  input logic [7:0] t1,
                                  input logic [7:0] t2);
    logic [7:0] t [K];
    bit ok = 1;
    t[0] = t0; t[1] = t1; t[2] = t2;
    for (int k = 0; k < K; k++)
      for (int w = 0; w < W; w++)
        if (b_win[k][w][0] !== pix(t[k], w, 0)) ok = 0;
    return ok;
  endfunction

  function automatic bit win_zero_a();
    bit ok = 1;
    for (int k = 0; k < K; k++)
      for (int w = 0; w < W; w++)
        for (int c = 0; c < CA; c++)
          if (a_win[k][w][c] !== 8'd0) ok = 0;
    return ok;
  endfunction

  task automatic a_fill(input logic [7:0] t);
    a_tag = t;
    for (int w = 0; w < W; w++)
      for (int c = 0; c < CA; c++)
        a_row[w][c] = pix(t, w, c);
  endtask

  task automatic b_fill(input logic [7:0] t);
    for (int w = 0; w < W; w++) b_row[w][0] = pix(t, w, 0);
  endtask

  task automatic a_cycle();
    @(posedge clk);
    #1;
    if (rand_ready) a_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic a_send(input logic [7:0] t, input bit last);
    bit done = 0;
    a_fill(t);
    a_in_last = last;
    a_in_valid = 1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = a_accept;
      a_cycle();
    end
    if (!done) check(0, "a_send_timeout", 0, 1);
    a_in_valid = 0;
    a_in_last = 0;
  endtask

  // Reference model: rows of the current image kept as tags;
  // a row at image index r yields a window of rows r-2..r when
  // r >= K-1 and (r-K+1) is a multiple of the stride.
  typedef struct packed {
    logic [7:0] t0;
    logic [7:0] t1;
    logic [7:0] t2;
    logic       last;
  } win_t;

  win_t exp_q[$];
  logic [7:0] img_q[$];
  bit pend_m = 0;
  int a_win_cnt = 0;
  int a_fe_cnt = 0;

  always @(negedge clk) begin : model
    bit ev, ea, ef, prod;
    int r;
    win_t w;
    if (!rst_n) begin
      exp_q.delete();
      img_q.delete();
      pend_m = 0;
    end else begin
      ev = (exp_q.size() != 0);
      ea = !ev || a_ready;
      check(a_valid == ev, "a_valid", int'(a_valid), int'(ev));
      check(a_accept == ea, "a_accept", int'(a_accept), int'(ea));
      if (a_valid && ev) begin
        check(win_ok_a(exp_q[0].t0, exp_q[0].t1, exp_q[0].t2),
              "a_window", int'(a_win[0][0][0]), int'(exp_q[0].t0));
        check(a_last == exp_q[0].last, "a_last",
              int'(a_last), int'(exp_q[0].last));
      end
      ef = pend_m || (ev && a_ready && exp_q[0].last);
      check(a_fe == ef, "a_frame_end", int'(a_fe), int'(ef));
      if (a_fe) a_fe_cnt++;
      if (a_valid && a_ready) a_win_cnt++;
      pend_m = 0;
      if (ev && a_ready) void'(exp_q.pop_front());
      if (a_in_valid && ea) begin
        r = img_q.size();
        img_q.push_back(a_tag);
        prod = (r >= K - 1) && ((r - K + 1) % SA == 0);
        if (prod) begin
          w.t0 = img_q[r-2];
          w.t1 = img_q[r-1];
          w.t2 = img_q[r];
          w.last = a_in_last;
          exp_q.push_back(w);
        end
        if (a_in_last) begin
          pend_m = !prod;
          img_q.delete();
        end
      end
    end
  end

  typedef struct {
    logic [7:0] tag;
    bit         last;
    bit         v;
    logic [7:0] first;
    bit         wl;
    bit         fe;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int w0, f0, bcnt;
    bit ev;
    // back-to-back 4-row images, then a 2-row and a 3-row image
    tbl[0]  = '{8'd0,  0, 0, 8'd0,  0, 0};
    tbl[1]  = '{8'd1,  0, 0, 8'd0,  0, 0};
    tbl[2]  = '{8'd2,  0, 1, 8'd0,  0, 0};
    tbl[3]  = '{8'd3,  1, 1, 8'd1,  1, 1};
    tbl[4]  = '{8'd4,  0, 0, 8'd0,  0, 0};
    tbl[5]  = '{8'd5,  0, 0, 8'd0,  0, 0};
    tbl[6]  = '{8'd6,  0, 1, 8'd4,  0, 0};
    tbl[7]  = '{8'd7,  1, 1, 8'd5,  1, 1};
    tbl[8]  = '{8'd20, 0, 0, 8'd0,  0, 0};
    tbl[9]  = '{8'd21, 1, 0, 8'd0,  0, 1};
    tbl[10] = '{8'd10, 0, 0, 8'd0,  0, 0};
    tbl[11] = '{8'd11, 0, 0, 8'd0,  0, 0};
    tbl[12] = '{8'd12, 1, 1, 8'd10, 1, 1};

    rst_n = 0;
    a_in_valid = 0; a_in_last = 0; a_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_ready = 0;
    a_fill(8'd0);
    b_fill(8'd0);
    repeat (2) @(posedge clk);
    #1;
    check(a_accept == 0, "rst_accept", int'(a_accept), 0);
    check(a_valid == 0, "rst_valid", int'(a_valid), 0);
    check(a_fe == 0 && a_last == 0, "rst_fe_last", int'(a_fe), 0);
    check(win_zero_a(), "rst_window", int'(a_win[0][0][0]), 0);
    check(b_accept == 0, "rst_b_accept", int'(b_accept), 0);
    @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;

    // full stride-1 image, ready held high
    a_ready = 1;
    w0 = a_win_cnt; f0 = a_fe_cnt;
    for (int r = 0; r < 28; r++) a_send(8'(r), r == 27);
    repeat (3) a_cycle();
    check(a_win_cnt - w0 == 26, "s1_windows", a_win_cnt - w0, 26);
    check(a_fe_cnt - f0 == 1, "s1_frame_end", a_fe_cnt - f0, 1);

    // backpressure on the first window
    a_ready = 0;
    w0 = a_win_cnt; f0 = a_fe_cnt;
    for (int r = 0; r < 3; r++) a_send(8'(r), 0);
    a_fill(8'd3);
    a_in_valid = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check(a_accept == 0, "bp_accept", int'(a_accept), 0);
      check(a_valid && win_ok_a(8'd0, 8'd1, 8'd2), "bp_hold",
            int'(a_win[0][0][0]), 0);
      @(posedge clk);
      #1;
    end
    a_ready = 1;
    for (int r = 3; r < 28; r++) a_send(8'(r), r == 27);
    repeat (3) a_cycle();
    check(a_win_cnt - w0 == 26, "bp_windows", a_win_cnt - w0, 26);
    check(a_fe_cnt - f0 == 1, "bp_frame_end", a_fe_cnt - f0, 1);

    // table: one row per cycle, outputs checked after each edge
    @(posedge clk);
    #1;
    a_fill(tbl[0].tag);
    a_in_last = tbl[0].last;
    a_in_valid = 1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      if (i < 12) begin
        a_fill(tbl[i+1].tag);
        a_in_last = tbl[i+1].last;
      end else begin
        a_in_valid = 0;
        a_in_last = 0;
      end
      @(negedge clk);
      check(a_valid == tbl[i].v, "tbl_valid",
            int'(a_valid), int'(tbl[i].v));
      if (tbl[i].v) begin
        check(win_ok_a(tbl[i].first, 8'(tbl[i].first + 1),
                       8'(tbl[i].first + 2)), "tbl_window",
              int'(a_win[0][0][0]), int'(tbl[i].first));
        check(a_last == tbl[i].wl, "tbl_last",
              int'(a_last), int'(tbl[i].wl));
      end
      check(a_fe == tbl[i].fe, "tbl_frame_end",
            int'(a_fe), int'(tbl[i].fe));
    end

    // stride 2 with an unaligned tail
    b_ready = 1;
    bcnt = 0;
    @(posedge clk);
    #1;
    b_fill(8'd0);
    b_in_valid = 1;
    for (int r = 0; r < 28; r++) begin
      @(posedge clk);
      #1;
      if (r < 27) begin
        b_fill(8'(r + 1));
        b_in_last = (r + 1 == 27);
      end else begin
        b_in_valid = 0;
        b_in_last = 0;
      end
      @(negedge clk);
      ev = (r >= 2) && ((r - 2) % 2 == 0);
      if (b_valid) bcnt++;
      check(b_valid == ev, "b_valid", int'(b_valid), int'(ev));
      if (ev) begin
        check(win_ok_b(8'(r - 2), 8'(r - 1), 8'(r)), "b_window",
              int'(b_win[0][0][0]), r - 2);
        check(b_last == 0, "b_last", int'(b_last), 0);
      end
      check(b_fe == (r == 27), "b_frame_end",
            int'(b_fe), int'(r == 27));
    end
    @(posedge clk);
    @(negedge clk);
    check(b_fe == 0 && b_valid == 0, "b_after", int'(b_fe), 0);
    check(bcnt == 13, "b_windows", bcnt, 13);
    @(posedge clk);
    #1;

    // asynchronous reset mid-image
    a_ready = 1;
    for (int r = 0; r < 10; r++) a_send(8'(40 + r), 0);
    #2;
    rst_n = 0;
    a_in_valid = 0;
    #1;
    check(a_accept == 0, "arst_accept", int'(a_accept), 0);
    check(a_valid == 0, "arst_valid", int'(a_valid), 0);
    check(a_fe == 0 && a_last == 0, "arst_fe_last", int'(a_fe), 0);
    check(win_zero_a(), "arst_window", int'(a_win[0][0][0]), 0);
    @(posedge clk);
    #2 rst_n = 1;
    #1;
    a_send(8'd100, 0);
    a_send(8'd101, 0);
    a_send(8'd102, 1);
    check(a_valid && win_ok_a(8'd100, 8'd101, 8'd102),
          "arst_first_window", int'(a_win[0][0][0]), 100);
    check(a_last == 1, "arst_first_last", int'(a_last), 1);
    repeat (2) a_cycle();

    // random images, random gaps, random ready
    rand_ready = 1;
    for (int img = 0; img < 20; img++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int r = 0; r < len; r++) begin
        a_send(8'($urandom_range(0, 255)), r == len - 1);
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) a_cycle();
      end
    end
    rand_ready = 0;
    a_ready = 1;
    repeat (4) a_cycle();
    check(exp_q.size() == 0 && a_valid == 0, "drain_empty",
          exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cnn_row_window.md
# cnn_row_window

Parametrised row-window buffer that sits between a row-streaming source and a `cnn_layer`. It accepts image rows over the `valid`/`accept`/`last` row handshake. It presents a vertical window of `KERNAL_SIZE` consecutive rows, advancing by a configurable vertical `STRIDE`, and marks frame boundaries so downstream layers see per-image termination. It generalises the single-row feed to multi-row, multi-channel, strided windows with output backpressure.

## Interface
- `VALUE_BITS`, 8: bits per pixel value.
- `WIDTH`, 28: pixels per row.
- `IN_CHANNELS`, 1: channels per pixel.
- `KERNAL_SIZE`, 3: rows per window, ≥1.
- `STRIDE`, 1: vertical stride between windows, ≥1.

Ports:
- `clock_i`  in  1: single clock, rising edge.
- `reset_i`  in  1: asynchronous, active-low reset.
- `in_row_i`  in  `[VALUE_BITS-1:0] [WIDTH][IN_CHANNELS]`: input row.
- `in_row_valid_i`  in  1: `in_row_i` is valid.
- `in_row_accept_o`  out  1: the block takes the row on this edge when valid is also high.
- `in_row_last_i`  in  1: qualifies the row as the final row of the image.
- `out_window_o`  out  `[VALUE_BITS-1:0] [KERNAL_SIZE][WIDTH][IN_CHANNELS]`: window. Index 0 is the oldest row.
- `out_window_valid_o`  out  1: the window is valid.
- `out_window_ready_i`  in  1: the consumer takes the window on this edge.
- `out_window_last_o`  out  1: this window is the last window of the image.
- `out_frame_end_o`  out  1: one-cycle pulse marking the end of an image.

## Operation
- Row storage is a `KERNAL_SIZE`-deep shift register of rows.
  - When a row is accepted, it enters at index `KERNAL_SIZE-1` and every other row moves down one index.
- Counters, both cleared at reset and after the last row of an image is accepted:
  - `row_idx`: row index within the image, saturating at `KERNAL_SIZE-1+STRIDE`.
  - `phase`: 0..`STRIDE-1`.
- An accepted row with in-image index `r` produces a window iff `r ≥ KERNAL_SIZE-1` and `(r-KERNAL_SIZE+1) mod STRIDE == 0`.
  - Track this with `phase`: reset `phase` to 0 on every produced window, increment it otherwise once the buffer is full.
- A produced window is registered: `out_window_valid_o` is set, and `out_window_o` equals the buffer contents after the shift.
- `out_window_last_o` = 1 iff the producing row had `in_row_last_i` = 1.
- When the last row is accepted:
  - If it produces a window, `out_frame_end_o` pulses in the cycle that window is accepted.
  - Otherwise, `out_frame_end_o` pulses in the cycle after the row is accepted, and no window is emitted. This covers an unaligned tail and an image shorter than `KERNAL_SIZE`.
- After the last row:
  - Counters clear.
  - Stale buffer rows remain but are never exposed: the next image needs `KERNAL_SIZE` new rows before its first window.
- `in_row_accept_o` = `reset_i & (~out_window_valid_o | out_window_ready_i)`. This is a combinational path from ready to accept.
- Valid/accept on the same edge as a window handoff: the old window is consumed and the new row shifts in. There is no lost or duplicated row.
- `out_window_valid_o` clears on an accepted window unless a new window is produced on the same edge.
- The input must hold `in_row_i`, `in_row_valid_i` and `in_row_last_i` stable until the row is accepted.
- The output holds `out_window_o`, `out_window_valid_o` and `out_window_last_o` stable while valid and not ready.

## Timing
- Reset asserted (low) asynchronously clears, immediately:
  - all outputs to 0, including `in_row_accept_o`;
  - buffer contents to 0;
  - `row_idx` and `phase`.
- Reset mid-image discards that image. The first window after release requires `KERNAL_SIZE` fresh rows.
- Latency: a row accepted on edge N has its window visible after edge N, with valid high during cycle N+1.
- Throughput: one row per cycle when `out_window_ready_i` is held 1. With `STRIDE=1`, one window per row after fill.
- `out_frame_end_o` is high for exactly one cycle per image.
- When `out_frame_end_o` coincides with a window (last row produces a window), the pulse occurs on the same edge the window is accepted.

## Test plan
- **Full stride-1 image.** Config `WIDTH=28`, `K=3`, `STRIDE=1`. Drive 28 rows with every pixel = row number and ready=1.
  - Expect 26 windows; window j holds rows {j, j+1, j+2}.
  - `out_window_last_o` = 1 only on window 25; `out_frame_end_o` pulses once, on the same edge window 25 is accepted.
- **Stride 2, unaligned tail.** Config `STRIDE=2`, 28 rows.
  - Expect 13 windows ending at rows 2, 4, …, 26, all with last = 0.
  - Row 27 (last) produces no window; `out_frame_end_o` pulses the cycle after row 27 is accepted.
- **Backpressure.** Config `STRIDE=1`. Hold ready = 0 for 5 cycles while the first window is valid.
  - `in_row_accept_o` = 0 and the window stays stable throughout.
  - After ready = 1, rows resume with no loss; the window sequence is identical to the first scenario.
- **Short image, then normal image.** Send 2 rows (last on row 1): no window, one `out_frame_end_o` pulse.
  - Then send 3 rows with values 10, 11, 12 (last on the third).
  - Expect one window {10, 11, 12} with last = 1, and one frame-end pulse.
- **Async reset mid-image.** Drop `reset_i` between edges after 10 rows.
  - valid, accept and all outputs go to 0 without waiting for a clock edge.
  - After release, rows 100, 101, 102 give a first window of exactly {100, 101, 102}.
- **Back-to-back images.** Config `STRIDE=1`, two 4-row images with no idle cycles.
  - Expect windows {0,1,2}, {1,2,3 last}, then {4,5,6}, {5,6,7 last}, with two frame-end pulses.
